// File: rtl/otp_array_ctrl_if.sv
// rtl/otp_array_ctrl_if.sv - request/response bus between host and OTP array controller
interface otp_array_ctrl_if #(
  parameter int ROWS        = 2,
  parameter int ADDR_WIDTH  = 1,
  parameter int RETRY_WIDTH = 3
);
  logic                   req_valid;
  logic                   req_ready;
  logic [1:0]             req_mode;
  logic [ADDR_WIDTH-1:0]  req_col;
  logic [ROWS-1:0]        req_data;
  logic                   resp_valid;
  logic                   resp_err;
  logic [RETRY_WIDTH-1:0] resp_retries;

  modport master (
    output req_valid, req_mode, req_col, req_data,
    input  req_ready, resp_valid, resp_err, resp_retries
  );

  modport slave (
    input  req_valid, req_mode, req_col, req_data,
    output req_ready, resp_valid, resp_err, resp_retries
  );
endinterface

// File: rtl/otp_array_ctrl.sv
// rtl/otp_array_ctrl.sv - OTP array controller: read/program sequencing, settle/pulse timing, bounded retry
// Optional program read-back verification enabled by defining OTP_VERIFY_READ_EN.
module otp_array_ctrl #(
  parameter int ROWS          = 2,
  parameter int COLS          = 2,
  parameter int ADDR_WIDTH    = (COLS > 1) ? $clog2(COLS) : 1,
  parameter int SETTLE_CYCLES = 4,
  parameter int PULSE_CYCLES  = 8,
  parameter int MAX_RETRY     = 3,
  parameter int RETRY_WIDTH   = $clog2(MAX_RETRY + 2)
) (
  input  logic                clk,
  input  logic                reset,
  otp_array_ctrl_if.slave     bus,
  input  logic [ROWS-1:0]     rd_bits,
  input  logic                writing_successful,
  output logic [2*COLS-1:0]   PL,
  output logic [COLS-1:0]     BL,
  output logic [ROWS-1:0]     WLN,
  output logic [ROWS-1:0]     WLP,
  output logic                PRG,
  output logic                read_active,
  output logic [ROWS-1:0]     data_out
);
  localparam int CNT_MAX = (SETTLE_CYCLES > PULSE_CYCLES) ? SETTLE_CYCLES : PULSE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_CYCLES - 1);
  localparam logic [1:0] MODE_READ = 2'b00;
  localparam logic [1:0] MODE_PROG = 2'b01;
  localparam logic [1:0] MODE_NOP  = 2'b10;

  typedef enum logic [2:0] {
    IDLE, RD_SETUP, RD_SENSE, PRG_SETUP, PRG_PULSE, PRG_VERIFY, DONE
  } state_t;

  typedef struct packed {
    logic [2*COLS-1:0] pl;
    logic [COLS-1:0]   bl;
    logic [ROWS-1:0]   wln;
    logic [ROWS-1:0]   wlp;
    logic              prg;
    logic              ra;
  } drv_t;

  // Driver levels are a pure function of the state and latched column/mask.
  function automatic drv_t drive_of(state_t s, logic [ADDR_WIDTH-1:0] col, logic [ROWS-1:0] mask);
    drv_t d;
    d.pl  = '0;
    d.bl  = '0;
    d.wln = '1;
    d.wlp = '1;
    d.prg = 1'b0;
    d.ra  = 1'b0;
    case (s)
      RD_SETUP, RD_SENSE: begin
        for (int c = 0; c < COLS; c++)
          if (int'(col) == c) d.pl[2*c +: 2] = 2'b10;
        d.wln = '0;
        d.ra  = (s == RD_SENSE);
      end
      PRG_SETUP, PRG_PULSE, PRG_VERIFY: begin
        for (int c = 0; c < COLS; c++) begin
          d.pl[2*c +: 2] = (int'(col) == c) ? 2'b11 : 2'b01;
          d.bl[c]        = (int'(col) == c);
        end
        d.wln = ~mask;
        d.wlp = ~mask;
        d.prg = (s == PRG_PULSE);
      end
      default: ;
    endcase
    return d;
  endfunction

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [RETRY_WIDTH-1:0] retry_cnt, retry_n;
  logic [1:0]             mode_q, mode_n;
  logic [ADDR_WIDTH-1:0]  col_q, col_n;
  logic [ROWS-1:0]        mask_q, mask_n, data_n;
  logic                   err_q, err_n;
  logic                   fail_pulse;
  logic                   ready_q, resp_valid_q;
  drv_t                   drv;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    retry_n    = retry_cnt;
    mode_n     = mode_q;
    col_n      = col_q;
    mask_n     = mask_q;
    data_n     = data_out;
    err_n      = err_q;
    fail_pulse = 1'b0;
    case (state)
      IDLE: if (bus.req_valid) begin
        mode_n  = bus.req_mode;
        col_n   = bus.req_col;
        mask_n  = bus.req_data;
        retry_n = '0;
        err_n   = 1'b0;
        state_n = DONE;
        if (bus.req_mode == 2'b11 || int'(bus.req_col) >= COLS) begin
          err_n = 1'b1;
        end else if (bus.req_mode == MODE_READ) begin
          state_n = RD_SETUP;
        end else if (bus.req_mode == MODE_PROG && bus.req_data != '0) begin
          state_n = PRG_SETUP;
          cnt_n   = SETTLE_LD;
        end
      end
      RD_SETUP: begin
        state_n = RD_SENSE;
        cnt_n   = SETTLE_LD;
      end
      RD_SENSE: if (cnt != '0) begin
        cnt_n = cnt - 1'b1;
      end else begin
        state_n = DONE;
`ifdef OTP_VERIFY_READ_EN
        data_n = rd_bits;
        if (mode_q == MODE_PROG && (rd_bits & mask_q) != mask_q) fail_pulse = 1'b1;
`else
        if (mode_q == MODE_READ) data_n = rd_bits;
`endif
      end
      PRG_SETUP: if (cnt != '0) begin
        cnt_n = cnt - 1'b1;
      end else begin
        state_n = PRG_PULSE;
        cnt_n   = PULSE_LD;
      end
      PRG_PULSE: if (cnt != '0) cnt_n = cnt - 1'b1;
                 else state_n = PRG_VERIFY;
      PRG_VERIFY:
`ifdef OTP_VERIFY_READ_EN
        if (writing_successful) state_n = RD_SETUP;
`else
        if (writing_successful) state_n = DONE;
`endif
        else fail_pulse = 1'b1;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // A failed pulse (analog flag or read-back mismatch) retries until the budget is spent.
    if (fail_pulse) begin
      if (int'(retry_cnt) < MAX_RETRY) begin
        retry_n = retry_cnt + 1'b1;
        state_n = PRG_PULSE;
        cnt_n   = PULSE_LD;
      end else begin
        state_n = DONE;
        err_n   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      retry_cnt    <= '0;
      mode_q       <= MODE_NOP;
      col_q        <= '0;
      mask_q       <= '0;
      data_out     <= '0;
      err_q        <= 1'b0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      drv          <= drive_of(IDLE, '0, '0);
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      retry_cnt    <= retry_n;
      mode_q       <= mode_n;
      col_q        <= col_n;
      mask_q       <= mask_n;
      data_out     <= data_n;
      err_q        <= err_n;
      ready_q      <= (state_n == IDLE);
      resp_valid_q <= (state_n == DONE);
      drv          <= drive_of(state_n, col_n, mask_n);
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_err     = err_q;
  assign bus.resp_retries = retry_cnt;
  assign PL               = drv.pl;
  assign BL               = drv.bl;
  assign WLN              = drv.wln;
  assign WLP              = drv.wlp;
  assign PRG              = drv.prg;
  assign read_active      = drv.ra;
endmodule
